// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// One access bundle describes a single request on the memory port.
package mem_pkg;

  localparam int unsigned MAX_WAIT_DEFAULT  = 4;
  localparam int unsigned MAX_BURST_DEFAULT = 2;

  typedef struct packed {
    logic        en;
    logic        wr;
    logic        wide;
    logic [15:0] addr;
    logic [15:0] din;
  } access_t;

  function automatic access_t idle_access();
    access_t a;
    a.en   = 1'b0;
    a.wr   = 1'b0;
    a.wide = 1'b0;
    a.addr = 16'h0000;
    a.din  = 16'h0000;
    return a;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 4-bit counter with synchronous clear that saturates at a run-time ceiling.
// Clear wins over increment.
module sat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] max,
  output logic [3:0] cnt
);

  logic [3:0] cnt_next;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = 4'd0;
    end else if (inc) begin
      if (cnt >= max) begin
        cnt_next = max;
      end else begin
        cnt_next = cnt + 4'd1;
      end
    end else begin
      cnt_next = cnt;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares memory port 1 between the CPU (priority) and a secondary DMA master.
// A wait/burst counter pair bounds how long the DMA can be starved.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEFAULT,
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_en,
  input  logic        cpu_wr,
  input  logic        cpu_wide,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_wait,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic        dma_wide,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_din,
  output logic        dma_gnt,
  output logic [15:0] dma_dout,
  output logic        dma_rvalid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic        mem_wide,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout
);

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  access_t    cpu_acc;
  access_t    dma_acc;
  access_t    sel_acc;
  logic [3:0] wait_cnt;
  logic [3:0] burst_cnt;
  logic       forced;
  logic       gnt;
  logic       rd_dma;
  logic       wait_inc;
  logic       burst_inc;

  assign cpu_acc = '{en: cpu_en, wr: cpu_wr, wide: cpu_wide, addr: cpu_addr, din: cpu_din};
  assign dma_acc = '{en: 1'b1, wr: dma_wr, wide: dma_wide, addr: dma_addr, din: dma_din};

  // DMA may pre-empt a busy CPU once starved long enough, or while a burst is in progress
  always_comb begin
    forced = 1'b0;
    if (wait_cnt == MAX_WAIT_C) begin
      forced = 1'b1;
    end else if ((burst_cnt != 4'd0) && (burst_cnt < MAX_BURST_C)) begin
      forced = 1'b1;
    end else begin
      forced = 1'b0;
    end
  end

  assign gnt      = rst_n && dma_req && (!cpu_en || forced);
  assign dma_gnt  = gnt;
  assign cpu_wait = cpu_en && gnt;

  // port mux; the port is kept idle while reset is held
  always_comb begin
    sel_acc = cpu_acc;
    if (!rst_n) begin
      sel_acc.en = 1'b0;
    end else if (gnt) begin
      sel_acc = dma_acc;
    end else begin
      sel_acc = cpu_acc;
    end
  end

  assign mem_en   = sel_acc.en;
  assign mem_wr   = sel_acc.wr;
  assign mem_wide = sel_acc.wide;
  assign mem_addr = sel_acc.addr;
  assign mem_din  = sel_acc.din;

  assign wait_inc  = dma_req && !gnt;
  assign burst_inc = gnt && cpu_en;

  sat_counter u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wait_inc),
    .clr   (!wait_inc),
    .max   (MAX_WAIT_C),
    .cnt   (wait_cnt)
  );

  // idle-CPU grants neither clear nor advance the burst count
  sat_counter u_burst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (burst_inc),
    .clr   (!gnt),
    .max   (MAX_BURST_C),
    .cnt   (burst_cnt)
  );

  // marks that the memory output next cycle belongs to a DMA read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dma <= 1'b0;
    end else begin
      rd_dma <= gnt && !dma_wr;
    end
  end

  assign dma_rvalid = rd_dma;
  assign cpu_dout   = mem_dout;
  assign dma_dout   = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected per-cycle port behaviour
// from a fairness-rule reference model; a negedge monitor pops and compares.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int MW = 4;
  localparam int MB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_en = 1'b0, cpu_wr = 1'b0, cpu_wide = 1'b0;
  logic [15:0] cpu_addr = 16'h0, cpu_din = 16'h0, cpu_dout;
  logic        cpu_wait;
  logic        dma_req = 1'b0, dma_wr = 1'b0, dma_wide = 1'b0;
  logic [15:0] dma_addr = 16'h0, dma_din = 16'h0, dma_dout;
  logic        dma_gnt, dma_rvalid;
  logic        mem_en, mem_wr, mem_wide;
  logic [15:0] mem_addr, mem_din;
  logic [15:0] mem_dout = 16'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(MW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_wide(cpu_wide), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_wide(dma_wide), .dma_addr(dma_addr),
    .dma_din(dma_din), .dma_gnt(dma_gnt), .dma_dout(dma_dout), .dma_rvalid(dma_rvalid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_wide(mem_wide), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // memory port model (synchronous read, little-endian 16-bit accesses)
  logic [7:0] mem_arr [65536];
  logic [7:0] ref_mem [65536];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) begin
        mem_arr[mem_addr] <= mem_din[7:0];
        if (mem_wide) mem_arr[mem_addr + 16'd1] <= mem_din[15:8];
      end else begin
        mem_dout <= mem_wide ? {mem_arr[mem_addr + 16'd1], mem_arr[mem_addr]}
                             : {8'h00, mem_arr[mem_addr]};
      end
    end
  end

  function automatic logic [15:0] ref_read(input logic [15:0] a, input logic w);
    return w ? {ref_mem[a + 16'd1], ref_mem[a]} : {8'h00, ref_mem[a]};
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic w, input logic [15:0] d);
    ref_mem[a] = d[7:0];
    if (w) ref_mem[a + 16'd1] = d[15:8];
  endtask

  typedef struct {
    logic        gnt, wt, en, wr, wide;
    logic [15:0] addr, din;
    logic        rvalid;
    logic [15:0] dma_data;
    logic        cpu_chk;
    logic [15:0] cpu_data;
  } exp_t;

  exp_t sb_q[$];

  // reference model state: how long the DMA has been refused, and how many
  // contested cycles it has taken in the current burst
  int          denied_run = 0;
  int          taken_run  = 0;
  logic        pend_dma_rd = 1'b0, pend_cpu_rd = 1'b0;
  logic [15:0] pend_dma_data = 16'h0, pend_cpu_data = 16'h0;

  task automatic cycle(input logic rstv, input access_t c, input access_t d, output logic g);
    exp_t e;
    logic forced;
    @(posedge clk);
    #1;
    rst_n    = rstv;
    cpu_en   = c.en;  cpu_wr = c.wr;  cpu_wide = c.wide;  cpu_addr = c.addr;  cpu_din = c.din;
    dma_req  = d.en;  dma_wr = d.wr;  dma_wide = d.wide;  dma_addr = d.addr;  dma_din = d.din;
    e = '{gnt: 1'b0, wt: 1'b0, en: 1'b0, wr: 1'b0, wide: 1'b0, addr: 16'h0, din: 16'h0,
          rvalid: 1'b0, dma_data: 16'h0, cpu_chk: 1'b0, cpu_data: 16'h0};
    g = 1'b0;
    if (!rstv) begin
      denied_run = 0; taken_run = 0; pend_dma_rd = 1'b0; pend_cpu_rd = 1'b0;
    end else begin
      forced = (denied_run == MW) || (taken_run > 0 && taken_run < MB);
      g = d.en && (!c.en || forced);
      e.gnt = g;
      e.wt  = c.en && g;
      if (g) begin
        e.en = 1'b1; e.wr = d.wr; e.wide = d.wide; e.addr = d.addr; e.din = d.din;
      end else begin
        e.en = c.en; e.wr = c.wr; e.wide = c.wide; e.addr = c.addr; e.din = c.din;
      end
      e.rvalid = pend_dma_rd;  e.dma_data = pend_dma_data;
      e.cpu_chk = pend_cpu_rd; e.cpu_data = pend_cpu_data;
      pend_dma_rd = g && !d.wr;
      if (g && !d.wr) pend_dma_data = ref_read(d.addr, d.wide);
      if (g && d.wr) ref_write(d.addr, d.wide, d.din);
      pend_cpu_rd = c.en && !g && !c.wr;
      if (c.en && !g && !c.wr) pend_cpu_data = ref_read(c.addr, c.wide);
      if (c.en && !g && c.wr) ref_write(c.addr, c.wide, c.din);
      if (d.en && !g) denied_run = (denied_run + 1 > MW) ? MW : denied_run + 1;
      else denied_run = 0;
      if (!g) taken_run = 0;
      else if (c.en) taken_run = (taken_run + 1 > MB) ? MB : taken_run + 1;
    end
    sb_q.push_back(e);
  endtask

  // monitor: compare the DUT's port against the oldest expectation each cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({dma_gnt, cpu_wait, mem_en} !== {e.gnt, e.wt, e.en}) begin
        errors++;
        $display("FAIL ctrl t=%0t gnt/wait/en got %b%b%b want %b%b%b", $time,
                 dma_gnt, cpu_wait, mem_en, e.gnt, e.wt, e.en);
      end
      if (e.en) begin
        checks++;
        if ({mem_wr, mem_wide, mem_addr, mem_din} !== {e.wr, e.wide, e.addr, e.din}) begin
          errors++;
          $display("FAIL port t=%0t wr/wide/addr/din got %b %b %h %h want %b %b %h %h", $time,
                   mem_wr, mem_wide, mem_addr, mem_din, e.wr, e.wide, e.addr, e.din);
        end
      end
      checks++;
      if (dma_rvalid !== e.rvalid) begin
        errors++;
        $display("FAIL rvalid t=%0t got %b want %b", $time, dma_rvalid, e.rvalid);
      end
      if (e.rvalid) begin
        checks++;
        if (dma_dout !== e.dma_data) begin
          errors++;
          $display("FAIL dma_dout t=%0t got %h want %h", $time, dma_dout, e.dma_data);
        end
      end
      if (e.cpu_chk) begin
        checks++;
        if (cpu_dout !== e.cpu_data) begin
          errors++;
          $display("FAIL cpu_dout t=%0t got %h want %h", $time, cpu_dout, e.cpu_data);
        end
      end
    end
  end

  function automatic access_t acc(input logic en, input logic wr, input logic wide,
                                  input logic [15:0] addr, input logic [15:0] din);
    access_t a;
    a.en = en; a.wr = wr; a.wide = wide; a.addr = addr; a.din = din;
    return a;
  endfunction

  task automatic direct_gnt(input string name, input logic want);
    #2;
    checks++;
    if (dma_gnt !== want) begin
      errors++;
      $display("FAIL %s t=%0t dma_gnt got %b want %b", name, $time, dma_gnt, want);
    end
  endtask

  initial begin
    logic    g;
    access_t c, d, idle;
    logic    d_active, c_hold, rv;
    idle = idle_access();
    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end

    // reset held with both masters requesting: nothing may reach the port
    for (int i = 0; i < 3; i++)
      cycle(1'b0, acc(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0), acc(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0), g);
    for (int i = 0; i < 10; i++) cycle(1'b1, idle, idle, g);

    // CPU idle: DMA read, DMA wide write, then CPU reads the written word back
    cycle(1'b1, idle, acc(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0), g);
    direct_gnt("idle_dma_rd", 1'b1);
    cycle(1'b1, idle, acc(1'b1, 1'b1, 1'b1, 16'h0102, 16'h1234), g);
    direct_gnt("idle_dma_wr", 1'b1);
    cycle(1'b1, acc(1'b1, 1'b0, 1'b1, 16'h0102, 16'h0), idle, g);
    cycle(1'b1, acc(1'b1, 1'b0, 1'b0, 16'h0103, 16'h0), idle, g);
    cycle(1'b1, idle, idle, g);

    // CPU and DMA both continuously busy: 4 denied, 2 granted, repeating
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, acc(1'b1, 1'b0, 1'b1, 16'h0200 + 16'(2 * i), 16'h0),
            acc(1'b1, 1'b0, 1'b1, 16'h0300 + 16'(2 * i), 16'h0), g);
      direct_gnt("contended_pattern", (i % 6) >= 4);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, idle, idle, g);

    // DMA gives up after 2 refused cycles; the next request waits the full 4
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, acc(1'b1, 1'b0, 1'b0, 16'h0400, 16'h0), acc(1'b1, 1'b0, 1'b0, 16'h0500, 16'h0), g);
      direct_gnt("early_drop", 1'b0);
    end
    cycle(1'b1, acc(1'b1, 1'b0, 1'b0, 16'h0400, 16'h0), idle, g);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, acc(1'b1, 1'b0, 1'b0, 16'h0401, 16'h0), acc(1'b1, 1'b0, 1'b0, 16'h0501, 16'h0), g);
      direct_gnt("rewait", i >= 4);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, idle, idle, g);

    // forced grant, CPU goes idle for one cycle, then resumes mid-burst
    for (int i = 0; i < 4; i++)
      cycle(1'b1, acc(1'b1, 1'b0, 1'b0, 16'h0600, 16'h0), acc(1'b1, 1'b1, 1'b0, 16'h0700, 16'h00AA), g);
    cycle(1'b1, acc(1'b1, 1'b0, 1'b0, 16'h0600, 16'h0), acc(1'b1, 1'b1, 1'b0, 16'h0700, 16'h00AA), g);
    direct_gnt("burst_first", 1'b1);
    cycle(1'b1, idle, acc(1'b1, 1'b1, 1'b0, 16'h0701, 16'h00BB), g);
    direct_gnt("burst_cpu_idle", 1'b1);
    cycle(1'b1, acc(1'b1, 1'b0, 1'b0, 16'h0600, 16'h0), acc(1'b1, 1'b1, 1'b0, 16'h0702, 16'h00CC), g);
    direct_gnt("burst_resume", 1'b1);
    cycle(1'b1, acc(1'b1, 1'b0, 1'b0, 16'h0600, 16'h0), acc(1'b1, 1'b1, 1'b0, 16'h0703, 16'h00DD), g);
    direct_gnt("burst_end", 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, idle, idle, g);

    // reset lands while a granted DMA read is in flight; CPU owns the port after release
    cycle(1'b1, idle, acc(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0), g);
    for (int i = 0; i < 2; i++)
      cycle(1'b0, acc(1'b1, 1'b0, 1'b1, 16'h0102, 16'h0), acc(1'b1, 1'b0, 1'b1, 16'h0104, 16'h0), g);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, acc(1'b1, 1'b0, 1'b1, 16'h0102, 16'h0), acc(1'b1, 1'b0, 1'b1, 16'h0104, 16'h0), g);
      direct_gnt("post_reset", i >= 4);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, idle, idle, g);

    // randomized traffic honouring the hold-until-served protocol of both masters
    d_active = 1'b0; c_hold = 1'b0; c = idle; d = idle;
    for (int n = 0; n < 600; n++) begin
      rv = ($urandom_range(0, 149) != 0);
      if (!rv) begin
        d_active = 1'b0; c_hold = 1'b0;
      end
      if (!d_active) begin
        d = idle;
        if ($urandom_range(0, 2) == 0) begin
          d = acc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'h0100 + 16'($urandom_range(0, 63)), 16'($urandom));
          d_active = 1'b1;
        end
      end
      if (!c_hold) begin
        c = acc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'h0100 + 16'($urandom_range(0, 63)), 16'($urandom));
      end
      cycle(rv, c, d, g);
      if (rv) begin
        if (g) d_active = 1'b0;
        c_hold = c.en && g;
      end
    end

    @(posedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single primary read/write port of `memory` between the `vixen` CPU and one secondary bus master (DMA / debug loader).
- The CPU has priority. A starvation counter guarantees the secondary master a bounded burst of port cycles.
- Sits between `vixen` (mem_* pins) and `memory` port 1, and inserts a wait/stall to the CPU when the port is taken from it.
- Memory read data is synchronous: it appears on mem_dout the cycle after mem_en.

Parameters:
- MAX_WAIT, 4: consecutive denied DMA cycles (CPU busy) before DMA is forced onto the port. Range 1..15.
- MAX_BURST, 2: maximum consecutive forced DMA grants while the CPU is requesting. Range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_en  in  1  CPU access request (same cycle as address)
- cpu_wr  in  1  CPU write strobe
- cpu_wide  in  1  CPU 16-bit access (else byte)
- cpu_addr  in  16  CPU byte address
- cpu_din  in  16  CPU write data
- cpu_dout  out  16  read data to CPU
- cpu_wait  out  1  CPU access not performed this cycle; CPU must hold request
- dma_req  in  1  DMA access request, held until granted
- dma_wr  in  1  DMA write strobe
- dma_wide  in  1  DMA 16-bit access
- dma_addr  in  16  DMA byte address
- dma_din  in  16  DMA write data
- dma_gnt  out  1  DMA access performed this cycle
- dma_dout  out  16  read data to DMA
- dma_rvalid  out  1  dma_dout valid (cycle after a granted DMA read)
- mem_en, mem_wr, mem_wide  out  1 each  to memory port 1
- mem_addr  out  16  to memory
- mem_din  out  16  to memory
- mem_dout  in  16  from memory

Behaviour:
- Registers: wait_cnt[3:0], burst_cnt[3:0], rd_dma (1 bit). All reset to 0 asynchronously on rst_n low. dma_rvalid therefore resets to 0.
- Grant logic (combinational): dma_gnt = dma_req && (!cpu_en || wait_cnt==MAX_WAIT || (burst_cnt!=0 && burst_cnt<MAX_BURST)).
- While rst_n is low, dma_gnt and cpu_wait are forced to 0 and mem_en is 0.
- cpu_wait = cpu_en && dma_gnt.
- Port mux: when dma_gnt, mem_* is driven from dma_*. Otherwise mem_* is driven from cpu_*, with mem_en = cpu_en.
- mem_wr and mem_wide are driven as-is from the selected master. mem_en = 0 when neither master requests.
- wait_cnt next value:
  - dma_req && !dma_gnt: increment, saturating at MAX_WAIT.
  - otherwise: 0.
- burst_cnt next value:
  - dma_gnt && cpu_en: increment, saturating at MAX_BURST.
  - !dma_gnt: 0.
  - dma_gnt && !cpu_en: unchanged (idle-CPU grants are free).
- rd_dma next value = dma_gnt && !dma_wr. dma_rvalid = rd_dma.
- Read data: cpu_dout = mem_dout and dma_dout = mem_dout, passthrough with no register. Each master qualifies the data by its own request timing.
- Latency: a granted access completes in its grant cycle. Read data is valid exactly 1 cycle later.
- DMA grant is registered-free (combinational), so the DMA master must hold its request until it samples dma_gnt at a rising edge.
- Fairness bound with the CPU continuously busy: the DMA waits at most MAX_WAIT cycles, then receives MAX_BURST consecutive cycles. The CPU then gets at least 1 cycle, because burst_cnt==MAX_BURST denies the DMA and clears the counters.
- Simultaneous events:
  - CPU idle and DMA requesting: DMA granted every cycle with no counting.
  - CPU resuming mid-burst: burst counting starts from the current burst_cnt.
- dma_req dropped mid-burst: wait_cnt and burst_cnt return to 0 the next cycle.
- Reset mid-operation: any in-flight read is abandoned and dma_rvalid is 0. The memory contents are not the arbiter's concern.

Decomposition:
- Shared package `mem_pkg` holds:
  - the access bundle typedef (en, wr, wide, addr[15:0], din[15:0]);
  - the MAX_WAIT / MAX_BURST default constants.
- One natural sub-module: `sat_counter` (4-bit saturating increment with clear), instanced twice for wait_cnt and burst_cnt.
- Muxing and grant logic stay in the top.

Test Plan:
1. Release reset with no requests. Response: mem_en=0, dma_gnt=0, cpu_wait=0, dma_rvalid=0 for 10 cycles.
2. CPU idle; DMA reads 0x0100, then writes 0x1234 wide to 0x0102. Response: dma_gnt=1 on both cycles. dma_rvalid=1 only the cycle after the read, with dma_dout = preloaded mem[0x0100]. Memory then reads back 0x1234 at 0x0102.
3. CPU issues continuous reads, DMA requests continuously, MAX_WAIT=4, MAX_BURST=2. Response:
   - dma_gnt pattern 0,0,0,0,1,1,0,0,0,0,1,1…
   - cpu_wait=1 exactly on the grant cycles;
   - mem_addr = dma_addr on those cycles.
4. CPU busy; DMA requests for 2 cycles, then drops. Response: no grant occurs, and wait_cnt returns to 0. A new request then waits the full 4 cycles.
5. CPU busy and DMA forced (first grant cycle); CPU drops cpu_en for 1 cycle, then resumes. Response: DMA granted on all three cycles, and burst_cnt holds at 1 during the idle cycle.
6. Assert rst_n low during a granted DMA read. Response: dma_rvalid=0, counters=0 immediately (asynchronous). After release, the CPU owns the port.
